mod2_1_sdf: RTL and testbench
=============================

MOD2_1_SDF -- requirements
Module: mod2_1_sdf

Interface
REQ-001 Parameters SHALL be: WIDTH, 13, input sample width; LANES, 8, parallel complex lanes per clock; DEPTH, 4, delay-buffer depth in clocks (>=1).
REQ-002 Ports SHALL be, in order: clk input 1 system clock; rst input 1 reset.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 en input 1: input block valid, driven by the previous stage's registered alert.
REQ-005 din_re, din_im input signed WIDTH x LANES: input block, lane index = position in block.
REQ-006 dout_re, dout_im output signed WIDTH+1 x LANES: registered butterfly result.
REQ-007 dout_valid output 1: dout carries a result this cycle.
REQ-008 alert_out output 1: en delayed one clock, for the next stage's enable.
REQ-009 err output 1: sticky protocol-violation flag.

Function
REQ-010 The block SHALL implement a radix-2 single-delay-feedback butterfly per lane: frame = 2*DEPTH consumed blocks; block i (0..DEPTH-1) pairs with block i+DEPTH.
REQ-011 States SHALL be IDLE, FILL, BF, FLUSH; a counter cnt (0..DEPTH-1) indexes the buffer.
REQ-012 IDLE: on en, write din to slot 0, cnt<=1 (or 0 when DEPTH=1), go FILL (BF when DEPTH=1); no output.
REQ-013 FILL: on en, write din to slot cnt; if pending=1, emit the old slot cnt value (read-before-write) with dout_valid=1 the next cycle; on cnt=DEPTH-1, cnt<=0, pending<=0, go BF.
REQ-014 BF: on en, a=slot cnt, b=din; emit a+b next cycle with dout_valid=1; write a-b to slot cnt; on cnt=DEPTH-1, cnt<=0, pending<=1, go POST-check.
REQ-015 Cycle after the last BF block: en=1 SHALL be treated as FILL slot 0 (back-to-back frame, no gap); en=0 SHALL enter FLUSH.
REQ-016 FLUSH: without en, emit slot cnt each cycle, cnt increments; after slot DEPTH-1, pending<=0, go IDLE.
REQ-017 en=0 in FILL or BF mid-frame SHALL stall: cnt, state, buffer hold; dout_valid=0 next cycle.
REQ-018 en=1 during FLUSH SHALL be ignored and SHALL set err (cleared only by rst).
REQ-019 Latency SHALL be exactly one clock from consumption (or FLUSH read) to dout.
REQ-020 Arithmetic SHALL be full precision: sign-extend to WIDTH+1, no rounding, no saturation; difference is a-b (earlier minus later).
REQ-021 dout SHALL hold its last value when dout_valid=0.

Reset
REQ-022 rst=1 at a clock edge SHALL set state IDLE, cnt 0, pending 0, dout_re/dout_im 0, dout_valid 0, alert_out 0, err 0.
REQ-023 rst mid-frame SHALL abandon the frame; stored differences SHALL never be emitted; buffer contents need not be cleared.

Structure
REQ-024 A shared package SHALL hold the WIDTH/LANES/DEPTH defaults and the state enum type.
REQ-025 The delay buffer SHALL be a sub-module mod2_1_dly_buf: DEPTH x LANES complex words, one read-before-write port, no reset.

Verification (DEPTH=4, LANES=8; lane 0 shown, other lanes lane0+lane-index)
REQ-026 Reset: hold rst 2 cycles -> all outputs 0, no dout_valid for 5 idle cycles.
REQ-027 Single frame: en 8 cycles, re=1,2,3,4,10,20,30,40, then en=0 -> sums 11,22,33,44 on cycles 6-9, then FLUSH diffs -9,-18,-27,-36 on cycles 10-13, then dout_valid=0.
REQ-028 Extremes: a=4095,b=4095 -> sum 8190; a=-4096,b=4095 -> diff -8191; im identical path.
REQ-029 Stall: en low 2 cycles after BF block 1 -> two dout_valid=0 gaps, values identical to REQ-027.
REQ-030 Back-to-back: second frame (100..800) starts immediately -> its FILL cycles emit -9,-18,-27,-36 with no idle gap.
REQ-031 Mid-frame reset and FLUSH violation: rst during BF -> outputs 0 next cycle, fresh frame matches REQ-027; en during FLUSH -> err=1 and stays 1.

Source files
------------

// File: rtl/mod2_1_sdf_pkg.sv
// Shared defaults, FSM state type and small helpers for the radix-2 SDF butterfly.
package mod2_1_sdf_pkg;

  localparam int unsigned DefWidth = 13;
  localparam int unsigned DefLanes = 8;
  localparam int unsigned DefDepth = 4;

  // StFill with pending set and cnt at 0 doubles as the post-frame decision point.
  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StBf,
    StFlush
  } state_e;

  // Counter width for a buffer of the given depth; never zero.
  function automatic int unsigned cnt_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mod2_1_dly_buf.sv
// Delay buffer: DEPTH words of LANES complex samples, one read-before-write port.
// Read is combinational from the addressed slot; the write lands on the clock edge,
// so a read and write to the same slot in one cycle returns the old contents.
module mod2_1_dly_buf
  import mod2_1_sdf_pkg::*;
#(
  parameter int unsigned DW    = DefWidth + 1,
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [LANES*DW-1:0]   wdata_re_i,
  input  logic [LANES*DW-1:0]   wdata_im_i,
  output logic [LANES*DW-1:0]   rdata_re_o,
  output logic [LANES*DW-1:0]   rdata_im_o
);

  logic [LANES*DW-1:0] mem_re [DEPTH];
  logic [LANES*DW-1:0] mem_im [DEPTH];

  // Storage write; deliberately no reset, stale contents are never emitted.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_re[addr_i] <= wdata_re_i;
      mem_im[addr_i] <= wdata_im_i;
    end
  end

  assign rdata_re_o = mem_re[addr_i];
  assign rdata_im_o = mem_im[addr_i];

endmodule

// File: rtl/mod2_1_sdf.sv
// Radix-2 single-delay-feedback butterfly, LANES parallel complex lanes per clock.
// A frame is 2*DEPTH blocks: the first DEPTH are buffered, each of the next DEPTH is
// combined with its partner; the sum goes out, the difference goes back to the buffer
// and leaves either during the next frame's fill or during a flush.
module mod2_1_sdf
  import mod2_1_sdf_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic signed [LANES*WIDTH-1:0]     din_re,
  input  logic signed [LANES*WIDTH-1:0]     din_im,
  output logic signed [LANES*(WIDTH+1)-1:0] dout_re,
  output logic signed [LANES*(WIDTH+1)-1:0] dout_im,
  output logic                              dout_valid,
  output logic                              alert_out,
  output logic                              err
);

  localparam int unsigned W1   = WIDTH + 1;
  localparam int unsigned BW   = LANES * W1;
  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic            alert_q;
  logic            vld_q, vld_d;
  logic [BW-1:0]   out_re_q, out_re_d;
  logic [BW-1:0]   out_im_q, out_im_d;

  logic            buf_we;
  logic [BW-1:0]   buf_wre, buf_wim;
  logic [BW-1:0]   buf_rre, buf_rim;
  logic [BW-1:0]   din_x_re, din_x_im;
  logic [BW-1:0]   sum_re, sum_im;
  logic [BW-1:0]   dif_re, dif_im;

  logic            cnt_last;
  logic [CntW-1:0] cnt_inc;

  assign cnt_last = (cnt_q == CntLast);
  assign cnt_inc  = cnt_last ? '0 : cnt_q + CntW'(1);

  mod2_1_dly_buf #(
    .DW    (W1),
    .LANES (LANES),
    .DEPTH (DEPTH),
    .AW    (CntW)
  ) u_dly_buf (
    .clk_i      (clk),
    .we_i       (buf_we),
    .addr_i     (cnt_q),
    .wdata_re_i (buf_wre),
    .wdata_im_i (buf_wim),
    .rdata_re_o (buf_rre),
    .rdata_im_o (buf_rim)
  );

  // Per-lane full-precision arithmetic: a is the buffered (earlier) word, b the new input.
  always_comb begin
    din_x_re = '0;
    din_x_im = '0;
    sum_re   = '0;
    sum_im   = '0;
    dif_re   = '0;
    dif_im   = '0;
    for (int l = 0; l < LANES; l++) begin
      din_x_re[l*W1 +: W1] = {din_re[l*WIDTH + WIDTH - 1], din_re[l*WIDTH +: WIDTH]};
      din_x_im[l*W1 +: W1] = {din_im[l*WIDTH + WIDTH - 1], din_im[l*WIDTH +: WIDTH]};
      sum_re[l*W1 +: W1]   = buf_rre[l*W1 +: W1] + din_x_re[l*W1 +: W1];
      sum_im[l*W1 +: W1]   = buf_rim[l*W1 +: W1] + din_x_im[l*W1 +: W1];
      dif_re[l*W1 +: W1]   = buf_rre[l*W1 +: W1] - din_x_re[l*W1 +: W1];
      dif_im[l*W1 +: W1]   = buf_rim[l*W1 +: W1] - din_x_im[l*W1 +: W1];
    end
  end

  // Next-state, buffer control and output selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    err_d    = err_q;
    buf_we   = 1'b0;
    buf_wre  = din_x_re;
    buf_wim  = din_x_im;
    vld_d    = 1'b0;
    out_re_d = out_re_q;
    out_im_d = out_im_q;

    case (state_q)
      StIdle: begin
        if (en) begin
          buf_we  = 1'b1;
          cnt_d   = cnt_inc;
          state_d = cnt_last ? StBf : StFill;
        end
      end

      StFill: begin
        if (en) begin
          // Read-before-write: the outgoing difference leaves as the new sample lands.
          buf_we = 1'b1;
          if (pend_q) begin
            vld_d    = 1'b1;
            out_re_d = buf_rre;
            out_im_d = buf_rim;
          end
          cnt_d = cnt_inc;
          if (cnt_last) begin
            pend_d  = 1'b0;
            state_d = StBf;
          end
        end else if (pend_q && (cnt_q == '0)) begin
          // No follow-on frame: this cycle is already the first flush read.
          vld_d    = 1'b1;
          out_re_d = buf_rre;
          out_im_d = buf_rim;
          cnt_d    = cnt_inc;
          if (cnt_last) begin
            pend_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StFlush;
          end
        end
      end

      StBf: begin
        if (en) begin
          buf_we   = 1'b1;
          buf_wre  = dif_re;
          buf_wim  = dif_im;
          vld_d    = 1'b1;
          out_re_d = sum_re;
          out_im_d = sum_im;
          cnt_d    = cnt_inc;
          if (cnt_last) begin
            pend_d  = 1'b1;
            state_d = StFill;
          end
        end
      end

      StFlush: begin
        // Flush runs unconditionally; input arriving now cannot be accepted.
        if (en) begin
          err_d = 1'b1;
        end
        vld_d    = 1'b1;
        out_re_d = buf_rre;
        out_im_d = buf_rim;
        cnt_d    = cnt_inc;
        if (cnt_last) begin
          pend_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      alert_q  <= 1'b0;
      vld_q    <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      alert_q  <= en;
      vld_q    <= vld_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  end

  assign dout_re    = out_re_q;
  assign dout_im    = out_im_q;
  assign dout_valid = vld_q;
  assign alert_out  = alert_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mod2_1_sdf.sv
// Directed bench for mod2_1_sdf at WIDTH=13, LANES=8, DEPTH=4.
// Lane l carries lane0 + step*l; imaginary inputs are the negated real ones unless noted.
module tb_mod2_1_sdf;

  localparam int WIDTH = 13;
  localparam int LANES = 8;
  localparam int DEPTH = 4;
  localparam int W1    = WIDTH + 1;

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic [LANES*WIDTH-1:0]   din_re, din_im;
  logic [LANES*W1-1:0]      dout_re, dout_im;
  logic                     dout_valid, alert_out, err;

  int n_chk;
  int n_pass;

  mod2_1_sdf #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din_re     (din_re),
    .din_im     (din_im),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .alert_out  (alert_out),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LANES*W1-1:0] mk(int b, int s);
    logic [LANES*W1-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*W1 +: W1] = W1'(b + s * l);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one block then advance one clock.
  task automatic drv(input logic e, input int r0, input int rs, input int i0, input int is);
    en = e;
    for (int l = 0; l < LANES; l++) begin
      din_re[l*WIDTH +: WIDTH] = WIDTH'(r0 + rs * l);
      din_im[l*WIDTH +: WIDTH] = WIDTH'(i0 + is * l);
    end
    tick();
  endtask

  task automatic blk(input logic e, input int r0);
    drv(e, r0, 1, -r0, -1);
  endtask

  task automatic chk(input string tag, input logic v, input int r0, input int rs,
                     input int i0, input int is);
    logic [LANES*W1-1:0] er, ei;
    er = mk(r0, rs);
    ei = mk(i0, is);
    n_chk++;
    assert (dout_valid === v && dout_re === er && dout_im === ei) n_pass++;
    else $error("FAIL %s: got valid=%0b re0=%0d im0=%0d re=%h im=%h, want valid=%0b re0=%0d im0=%0d re=%h im=%h",
                tag, dout_valid, $signed(dout_re[W1-1:0]), $signed(dout_im[W1-1:0]),
                dout_re, dout_im, v, r0, i0, er, ei);
  endtask

  task automatic chk_flags(input string tag, input logic a, input logic e);
    n_chk++;
    assert (alert_out === a && err === e) n_pass++;
    else $error("FAIL %s: got alert_out=%0b err=%0b, want alert_out=%0b err=%0b",
                tag, alert_out, err, a, e);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    en     = 1'b0;
    din_re = '0;
    din_im = '0;

    // Reset held two cycles, then idle.
    tick();
    tick();
    chk("rst_out", 1'b0, 0, 0, 0, 0);
    chk_flags("rst_flags", 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle", 1'b0, 0, 0, 0, 0);
    end

    // Single frame then flush.
    blk(1'b1, 1);
    chk("fill0", 1'b0, 0, 0, 0, 0);
    chk_flags("alert_hi", 1'b1, 1'b0);
    blk(1'b1, 2);
    blk(1'b1, 3);
    blk(1'b1, 4);
    chk("fill3", 1'b0, 0, 0, 0, 0);
    blk(1'b1, 10);  chk("sum0", 1'b1, 11, 2, -11, -2);
    blk(1'b1, 20);  chk("sum1", 1'b1, 22, 2, -22, -2);
    blk(1'b1, 30);  chk("sum2", 1'b1, 33, 2, -33, -2);
    blk(1'b1, 40);  chk("sum3", 1'b1, 44, 2, -44, -2);
    blk(1'b0, 0);   chk("dif0", 1'b1, -9, 0, 9, 0);
    chk_flags("alert_lo", 1'b0, 1'b0);
    blk(1'b0, 0);   chk("dif1", 1'b1, -18, 0, 18, 0);
    blk(1'b0, 0);   chk("dif2", 1'b1, -27, 0, 27, 0);
    blk(1'b0, 0);   chk("dif3", 1'b1, -36, 0, 36, 0);
    blk(1'b0, 0);   chk("post_hold", 1'b0, -36, 0, 36, 0);
    blk(1'b0, 0);   chk("post_idle", 1'b0, -36, 0, 36, 0);

    // Extremes: same value on every lane, im follows re.
    drv(1'b1, 4095, 0, 4095, 0);
    drv(1'b1, -4096, 0, -4096, 0);
    drv(1'b1, 0, 0, 0, 0);
    drv(1'b1, 0, 0, 0, 0);
    drv(1'b1, 4095, 0, 4095, 0);  chk("ext_sum", 1'b1, 8190, 0, 8190, 0);
    drv(1'b1, 4095, 0, 4095, 0);  chk("ext_sum_neg", 1'b1, -1, 0, -1, 0);
    drv(1'b1, 0, 0, 0, 0);
    drv(1'b1, 0, 0, 0, 0);
    drv(1'b0, 0, 0, 0, 0);        chk("ext_dif0", 1'b1, 0, 0, 0, 0);
    drv(1'b0, 0, 0, 0, 0);        chk("ext_dif", 1'b1, -8191, 0, -8191, 0);
    drv(1'b0, 0, 0, 0, 0);
    drv(1'b0, 0, 0, 0, 0);
    drv(1'b0, 0, 0, 0, 0);        chk("ext_idle", 1'b0, 0, 0, 0, 0);

    // Stall for two cycles after the first butterfly block.
    blk(1'b1, 1);
    blk(1'b1, 2);
    blk(1'b1, 3);
    blk(1'b1, 4);
    blk(1'b1, 10);  chk("st_sum0", 1'b1, 11, 2, -11, -2);
    blk(1'b0, 0);   chk("st_gap0", 1'b0, 11, 2, -11, -2);
    blk(1'b0, 0);   chk("st_gap1", 1'b0, 11, 2, -11, -2);
    blk(1'b1, 20);  chk("st_sum1", 1'b1, 22, 2, -22, -2);
    blk(1'b1, 30);  chk("st_sum2", 1'b1, 33, 2, -33, -2);
    blk(1'b1, 40);  chk("st_sum3", 1'b1, 44, 2, -44, -2);
    blk(1'b0, 0);   chk("st_dif0", 1'b1, -9, 0, 9, 0);
    blk(1'b0, 0);
    blk(1'b0, 0);
    blk(1'b0, 0);   chk("st_dif3", 1'b1, -36, 0, 36, 0);
    blk(1'b0, 0);   chk("st_idle", 1'b0, -36, 0, 36, 0);

    // Back-to-back frames.
    blk(1'b1, 1);
    blk(1'b1, 2);
    blk(1'b1, 3);
    blk(1'b1, 4);
    blk(1'b1, 10);
    blk(1'b1, 20);
    blk(1'b1, 30);
    blk(1'b1, 40);  chk("bb_sum3", 1'b1, 44, 2, -44, -2);
    blk(1'b1, 100); chk("bb_dif0", 1'b1, -9, 0, 9, 0);
    blk(1'b1, 200); chk("bb_dif1", 1'b1, -18, 0, 18, 0);
    blk(1'b1, 300); chk("bb_dif2", 1'b1, -27, 0, 27, 0);
    blk(1'b1, 400); chk("bb_dif3", 1'b1, -36, 0, 36, 0);
    blk(1'b1, 500); chk("bb2_sum0", 1'b1, 600, 2, -600, -2);
    blk(1'b1, 600);
    blk(1'b1, 700);
    blk(1'b1, 800); chk("bb2_sum3", 1'b1, 1200, 2, -1200, -2);
    blk(1'b0, 0);   chk("bb2_dif0", 1'b1, -400, 0, 400, 0);
    blk(1'b0, 0);
    blk(1'b0, 0);
    blk(1'b0, 0);   chk("bb2_dif3", 1'b1, -400, 0, 400, 0);
    blk(1'b0, 0);   chk("bb2_idle", 1'b0, -400, 0, 400, 0);

    // Reset in the middle of the butterfly phase, then a fresh frame.
    blk(1'b1, 1);
    blk(1'b1, 2);
    blk(1'b1, 3);
    blk(1'b1, 4);
    blk(1'b1, 10);  chk("mr_sum0", 1'b1, 11, 2, -11, -2);
    rst = 1'b1;
    blk(1'b1, 20);  chk("mr_rst", 1'b0, 0, 0, 0, 0);
    chk_flags("mr_flags", 1'b0, 1'b0);
    rst = 1'b0;
    blk(1'b1, 1);   chk("mr_fill0", 1'b0, 0, 0, 0, 0);
    blk(1'b1, 2);   chk("mr_fill1", 1'b0, 0, 0, 0, 0);
    blk(1'b1, 3);
    blk(1'b1, 4);   chk("mr_fill3", 1'b0, 0, 0, 0, 0);
    blk(1'b1, 10);  chk("mr_sum0b", 1'b1, 11, 2, -11, -2);
    blk(1'b1, 20);
    blk(1'b1, 30);
    blk(1'b1, 40);  chk("mr_sum3", 1'b1, 44, 2, -44, -2);
    blk(1'b0, 0);   chk("mr_dif0", 1'b1, -9, 0, 9, 0);
    blk(1'b0, 0);   chk("mr_dif1", 1'b1, -18, 0, 18, 0);
    blk(1'b0, 0);   chk("mr_dif2", 1'b1, -27, 0, 27, 0);
    blk(1'b0, 0);   chk("mr_dif3", 1'b1, -36, 0, 36, 0);
    blk(1'b0, 0);   chk("mr_idle", 1'b0, -36, 0, 36, 0);

    // Input offered during flush: ignored, err sticks until reset.
    blk(1'b1, 1);
    blk(1'b1, 2);
    blk(1'b1, 3);
    blk(1'b1, 4);
    blk(1'b1, 10);
    blk(1'b1, 20);
    blk(1'b1, 30);
    blk(1'b1, 40);
    blk(1'b0, 0);   chk("fv_dif0", 1'b1, -9, 0, 9, 0);
    chk_flags("fv_pre", 1'b0, 1'b0);
    blk(1'b1, 55);  chk("fv_dif1", 1'b1, -18, 0, 18, 0);
    chk_flags("fv_err", 1'b1, 1'b1);
    blk(1'b0, 0);   chk("fv_dif2", 1'b1, -27, 0, 27, 0);
    blk(1'b0, 0);   chk("fv_dif3", 1'b1, -36, 0, 36, 0);
    blk(1'b0, 0);   chk("fv_idle", 1'b0, -36, 0, 36, 0);
    blk(1'b0, 0);
    chk_flags("fv_sticky", 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_flags("fv_clr", 1'b0, 1'b0);
    chk("fv_rst_out", 1'b0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
